gpu_vram_arbiter: RTL and testbench

Shares the single VRAM port between the graphics pixel renderer and the CPU bus interface.
- The renderer has absolute priority inside a render window derived from h_count/v_count.
- CPU read/write requests are buffered in a small FIFO and drained one per cycle outside the window.
- CPU read data returns with fixed latency.
- Sits between gpu_pixel_renderer, the CPU register/bus bridge and the VRAM macro, in the clk_pixel domain.

---
 rtl/gpu_vram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_gpu_vram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_vram_arbiter.sv
// gpu_vram_arbiter
//   Shares the single VRAM port between the pixel renderer and the CPU bus bridge.
//   The renderer owns the port inside the render window, which covers the visible
//   area plus a PREFETCH-clock priming slot before each visible line. CPU requests
//   are queued in a small FIFO and issued one per cycle outside the window. CPU
//   read data returns as a one-cycle pulse two cycles after issue.
//
//   Optional feature: define VRAM_ARB_STATS_EN to build a saturating counter of
//   cycles in which the CPU presented a request that the full FIFO refused.
//   Without the macro, cpu_stall_cycles is tied to zero.
//
// Ports
//   clk_pixel, rst_n                   pixel clock, async active-low reset
//   h_count, v_count, render_en        raster position and graphics-mode enable
//   rnd_addr / rnd_data                renderer address in, read data out (= vram_q)
//   cpu_req_valid/ready/we/addr/wdata  CPU request handshake into the FIFO
//   cpu_rd_valid / cpu_rd_data         CPU read return (one-cycle pulse)
//   fifo_level                         current FIFO occupancy
//   vram_addr/we/wdata, vram_q         VRAM macro port
//   cpu_stall_cycles                   stall statistic (see above)
module gpu_vram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_ACTIVE   = 400,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned PREFETCH   = 4
) (
  input  logic                          clk_pixel,
  input  logic                          rst_n,
  input  logic [9:0]                    h_count,
  input  logic [9:0]                    v_count,
  input  logic                          render_en,
  input  logic [14:0]                   rnd_addr,
  output logic [7:0]                    rnd_data,
  input  logic                          cpu_req_valid,
  output logic                          cpu_req_ready,
  input  logic                          cpu_req_we,
  input  logic [14:0]                   cpu_req_addr,
  input  logic [7:0]                    cpu_req_wdata,
  output logic                          cpu_rd_valid,
  output logic [7:0]                    cpu_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [14:0]                   vram_addr,
  output logic                          vram_we,
  output logic [7:0]                    vram_wdata,
  input  logic [7:0]                    vram_q,
  output logic [15:0]                   cpu_stall_cycles
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [LvlW-1:0] lvl_t;

  localparam logic [9:0] HActive   = 10'(H_ACTIVE);
  localparam logic [9:0] HPrefetch = 10'(H_TOTAL - PREFETCH);
  localparam logic [9:0] VActive   = 10'(V_ACTIVE);
  localparam logic [9:0] VPreLast  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam lvl_t       LvlFull   = lvl_t'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Render window
  // ---------------------------------------------------------------------------
  logic render_win;

  always_comb begin
    render_win = 1'b0;
    if (render_en) begin
      if (v_count < VActive && h_count < HActive) begin
        render_win = 1'b1;
      end
      // Priming slot at the end of a line that precedes a visible line; the
      // last frame line primes line 0 of the next frame.
      if (h_count >= HPrefetch && (v_count < VPreLast || v_count == VLast)) begin
        render_win = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CPU request FIFO
  // ---------------------------------------------------------------------------
  logic [14:0] addr_mem  [FIFO_DEPTH];
  logic        we_mem    [FIFO_DEPTH];
  logic [7:0]  wdata_mem [FIFO_DEPTH];

  ptr_t wr_ptr_q, rd_ptr_q;
  lvl_t level_q, level_d;
  logic fifo_full, fifo_empty;
  logic push, pop;

  assign fifo_full     = (level_q == LvlFull);
  assign fifo_empty    = (level_q == '0);
  // Readiness depends only on the registered level: no pass-through when full.
  assign cpu_req_ready = !fifo_full;
  assign push          = cpu_req_valid && cpu_req_ready;
  assign fifo_level    = level_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + lvl_t'(1);
    end else if (pop && !push) begin
      level_d = level_q - lvl_t'(1);
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      level_q <= level_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= cpu_req_addr;
      we_mem[wr_ptr_q]    <= cpu_req_we;
      wdata_mem[wr_ptr_q] <= cpu_req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Port mux
  // ---------------------------------------------------------------------------
  logic head_we;
  assign head_we = we_mem[rd_ptr_q];

  always_comb begin
    vram_addr  = rnd_addr;
    vram_we    = 1'b0;
    vram_wdata = '0;
    pop        = 1'b0;
    // A request pushed into an empty FIFO is not visible here until next cycle.
    if (!render_win && !fifo_empty) begin
      vram_addr  = addr_mem[rd_ptr_q];
      vram_we    = head_we;
      vram_wdata = wdata_mem[rd_ptr_q];
      pop        = 1'b1;
    end
  end

  assign rnd_data = vram_q;

  // ---------------------------------------------------------------------------
  // CPU read return: issue (N) -> vram_q valid (N+1) -> pulse (N+2)
  // ---------------------------------------------------------------------------
  logic       rd_issue_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      rd_issue_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_issue_q <= pop && !head_we;
      rd_valid_q <= rd_issue_q;
      if (rd_issue_q) rd_data_q <= vram_q;
    end
  end

  assign cpu_rd_valid = rd_valid_q;
  assign cpu_rd_data  = rd_data_q;

  // ---------------------------------------------------------------------------
  // Stall statistic
  // ---------------------------------------------------------------------------
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (cpu_req_valid && !cpu_req_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign cpu_stall_cycles = stall_q;
`else
  assign cpu_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_gpu_vram_arbiter.sv
// Testbench for gpu_vram_arbiter: directed raster scenarios followed by randomized
// traffic, checked against a transaction-level model (request queue, reference
// memory, expected read-return schedule) and a read-data scoreboard.
module tb_gpu_vram_arbiter;

  localparam int FIFO_DEPTH = 4;
  localparam int H_ACTIVE   = 640;
  localparam int H_TOTAL    = 800;
  localparam int V_ACTIVE   = 400;
  localparam int V_TOTAL    = 525;
  localparam int PREFETCH   = 4;

  logic                        clk_pixel = 1'b0;
  logic                        rst_n;
  logic [9:0]                  h_count, v_count;
  logic                        render_en;
  logic [14:0]                 rnd_addr;
  logic [7:0]                  rnd_data;
  logic                        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [14:0]                 cpu_req_addr;
  logic [7:0]                  cpu_req_wdata;
  logic                        cpu_rd_valid;
  logic [7:0]                  cpu_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [14:0]                 vram_addr;
  logic                        vram_we;
  logic [7:0]                  vram_wdata;
  logic [7:0]                  vram_q;
  logic [15:0]                 cpu_stall_cycles;

  gpu_vram_arbiter #(
    .FIFO_DEPTH(FIFO_DEPTH), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .PREFETCH(PREFETCH)
  ) dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .render_en(render_en), .rnd_addr(rnd_addr), .rnd_data(rnd_data),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_rd_valid(cpu_rd_valid),
    .cpu_rd_data(cpu_rd_data), .fifo_level(fifo_level), .vram_addr(vram_addr),
    .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_q(vram_q),
    .cpu_stall_cycles(cpu_stall_cycles)
  );

  always #20 clk_pixel = ~clk_pixel;

  // VRAM macro: registered read, one-cycle latency.
  logic [7:0] vram_mem [32768];
  always @(posedge clk_pixel) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    vram_q <= vram_mem[vram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [14:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } op_t;

  op_t        ops[$];        // requests accepted but not yet issued, in order
  int         rd_sched[$];   // cycles at which a read pulse is due
  logic [7:0] exp_data[$];   // scoreboard: read data in return order
  logic [7:0] ref_mem [32768];
  int         exp_stall = 0;

  // Renderer owns the port on visible pixels, and during the last PREFETCH
  // clocks of any line whose successor line is visible.
  function automatic bit ref_win(input bit en, input int h, input int v);
    int next_line;
    next_line = (v + 1) % V_TOTAL;
    return en && ((v < V_ACTIVE && h < H_ACTIVE) ||
                  (h >= H_TOTAL - PREFETCH && next_line < V_ACTIVE));
  endfunction

  int  pre_size;
  bit  win, exp_valid;
  op_t nop;

  always @(negedge clk_pixel) begin
    cyc++;
    if (!rst_n) begin
      ops.delete();
      rd_sched.delete();
      exp_data.delete();
      exp_stall = 0;
      chk("reset_level", 32'(fifo_level), 0);
      chk("reset_ready", 32'(cpu_req_ready), 1);
      chk("reset_rd_valid", 32'(cpu_rd_valid), 0);
      chk("reset_rd_data", 32'(cpu_rd_data), 0);
    end else begin
      pre_size = ops.size();
      win = ref_win(render_en, int'(h_count), int'(v_count));
      chk("fifo_level", 32'(fifo_level), 32'(pre_size));
      chk("cpu_req_ready", 32'(cpu_req_ready), 32'(pre_size < FIFO_DEPTH));
      chk("rnd_data", 32'(rnd_data), 32'(vram_q));
      chk("stall_cycles", 32'(cpu_stall_cycles), 32'(exp_stall));
      exp_valid = (rd_sched.size() > 0) && (rd_sched[0] == cyc);
      if (exp_valid) void'(rd_sched.pop_front());
      chk("cpu_rd_valid", 32'(cpu_rd_valid), 32'(exp_valid));

      if (!win && pre_size > 0) begin
        chk("issue_addr", 32'(vram_addr), 32'(ops[0].addr));
        chk("issue_we", 32'(vram_we), 32'(ops[0].we));
        if (ops[0].we) chk("issue_wdata", 32'(vram_wdata), 32'(ops[0].wdata));
        else rd_sched.push_back(cyc + 2);
        void'(ops.pop_front());
      end else begin
        chk("idle_we", 32'(vram_we), 0);
        chk("idle_addr", 32'(vram_addr), 32'(rnd_addr));
      end

      if (cpu_req_valid && pre_size < FIFO_DEPTH) begin
        nop.addr = cpu_req_addr;
        nop.we = cpu_req_we;
        nop.wdata = cpu_req_wdata;
        ops.push_back(nop);
        // Strict ordering means the reference memory at accept time is exactly
        // what a read will observe when it eventually issues.
        if (cpu_req_we) ref_mem[cpu_req_addr] = cpu_req_wdata;
        else exp_data.push_back(ref_mem[cpu_req_addr]);
      end else if (cpu_req_valid) begin
`ifdef VRAM_ARB_STATS_EN
        if (exp_stall < 16'hFFFF) exp_stall++;
`endif
      end
    end
  end

  // Scoreboard monitor: compares read data whenever the DUT pulses.
  always @(negedge clk_pixel) begin
    if (rst_n && cpu_rd_valid) begin
      if (exp_data.size() == 0) chk("rd_unexpected", 32'(cpu_rd_data), 32'hFFFF_FFFF);
      else chk("rd_data", 32'(cpu_rd_data), 32'(exp_data.pop_front()));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic req(input logic we, input logic [14:0] a, input logic [7:0] d);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    step();
    cpu_req_valid = 1'b0;
  endtask

  task automatic adv();
    if (h_count == 10'(H_TOTAL - 1)) begin
      h_count = '0;
      v_count = (v_count == 10'(V_TOTAL - 1)) ? '0 : v_count + 10'd1;
    end else begin
      h_count = h_count + 10'd1;
    end
  endtask

  logic [15:0] s0;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      vram_mem[i] = 8'h00;
      ref_mem[i]  = 8'h00;
    end
    vram_mem[15'h0040] = 8'h3C;
    ref_mem[15'h0040]  = 8'h3C;

    rst_n = 1'b0; render_en = 1'b1; h_count = 10'd700; v_count = 10'd10;
    rnd_addr = 15'h1234; cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
    cpu_req_addr = '0; cpu_req_wdata = '0;
    step(); step(); step();
    rst_n = 1'b1;
    step();

    // Blanking write issues the cycle after it is accepted.
    req(1'b1, 15'h0123, 8'hA5);
    step(); step();

    // Read latency, then write-then-read and back-to-back reads.
    req(1'b0, 15'h0040, 8'h00);
    step(); step(); step();
    req(1'b1, 15'h0050, 8'h77);
    req(1'b0, 15'h0050, 8'h00);
    req(1'b0, 15'h0040, 8'h00);
    req(1'b0, 15'h0123, 8'h00);
    repeat (5) step();

    // Window blocking: fill the FIFO, stall 10 cycles, drain from h=640.
    h_count = 10'd100; v_count = 10'd50; rnd_addr = 15'h2AAA;
    for (int i = 0; i < 4; i++) req(1'b1, 15'h0100 + 15'(i), 8'h10 + 8'(i));
    s0 = cpu_stall_cycles;
    cpu_req_valid = 1'b1;
    repeat (10) step();
    cpu_req_valid = 1'b0;
`ifdef VRAM_ARB_STATS_EN
    chk("stall_window_10", 32'(cpu_stall_cycles - s0), 10);
`else
    chk("stall_disabled", 32'(cpu_stall_cycles), 0);
`endif
    h_count = 10'd638;
    repeat (8) begin step(); adv(); end

    // Prefetch boundary: 795 issues, 796..799 block, then v=399 h=797 issues.
    h_count = 10'd100; v_count = 10'd20;
    for (int i = 0; i < 3; i++) req(1'b0, 15'h0100 + 15'(i), 8'h00);
    h_count = 10'd795;
    repeat (6) begin step(); adv(); end
    h_count = 10'd797; v_count = 10'd399;
    repeat (4) step();

    // Reset while a read pulse is due next cycle.
    h_count = 10'd700; v_count = 10'd10;
    req(1'b0, 15'h0040, 8'h00);
    step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        v_count = 10'($urandom_range(0, V_TOTAL - 1));
        h_count = 10'($urandom_range(600, H_TOTAL - 1));
      end else begin
        adv();
      end
      render_en     = ($urandom_range(0, 19) != 0);
      cpu_req_valid = ($urandom_range(0, 99) < 55);
      cpu_req_we    = 1'($urandom_range(0, 1));
      cpu_req_addr  = 15'($urandom_range(0, 15));
      cpu_req_wdata = 8'($urandom);
      rnd_addr      = 15'($urandom);
      step();
    end

    cpu_req_valid = 1'b0;
    render_en     = 1'b0;
    repeat (12) step();
    chk("sb_drained", 32'(exp_data.size()), 0);
    chk("reads_returned", 32'(rd_sched.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
